mux_array_gather: RTL and testbench

//  Gathering counterpart to the 1:4 array demux. Merges four array-wide input streams
//  (e.g. four PE-tile result buses) into one registered output stream.

---
 rtl/mux_array_gather_if.sv | 32 +++
 rtl/mux_array_gather.sv | 144 ++++++++++++++
 tb/tb_mux_array_gather.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_array_gather_if.sv
// Handshake bundle for the 4:1 array gather: four input streams, selection
// controls and one tagged output stream.
interface mux_array_gather_if #(
    parameter int array_size = 9,
    parameter int data_size  = 8
);
    localparam int W = array_size * data_size;

    logic [W-1:0] d_in_1;
    logic [W-1:0] d_in_2;
    logic [W-1:0] d_in_3;
    logic [W-1:0] d_in_4;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         sel_mode;
    logic [1:0]   sel;
    logic [W-1:0] d_out;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;
    logic         out_last;

    modport master (
        output d_in_1, d_in_2, d_in_3, d_in_4, in_valid, sel_mode, sel, out_ready,
        input  in_ready, d_out, out_valid, out_src, out_last
    );

    modport slave (
        input  d_in_1, d_in_2, d_in_3, d_in_4, in_valid, sel_mode, sel, out_ready,
        output in_ready, d_out, out_valid, out_src, out_last
    );
endinterface

// File: rtl/mux_array_gather.sv
// Four-to-one gather of array-wide streams into one registered output, with
// round-robin or fixed selection and grants held for whole bursts.
module mux_array_gather #(
    parameter int array_size = 9,
    parameter int data_size  = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux_array_gather_if.slave  bus
);
    localparam int W  = array_size * data_size;
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    lock_ch_q, lock_ch_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [W-1:0]  d_out_q, d_out_d;
    logic [1:0]    out_src_q, out_src_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic          load_s;
    logic          grant_vld_s;
    logic [1:0]    grant_s;
    logic [3:0]    in_ready_s;
    logic          xfer_s;
    logic          burst_end_s;
    logic [W-1:0]  grant_data_s;

    assign load_s      = ~out_valid_q | bus.out_ready;
    assign burst_end_s = (beat_cnt_q == CW'(BURST_LEN - 1));
    assign xfer_s      = |(in_ready_s & bus.in_valid);

    // Candidate channel: locked owner, else fixed select, else round-robin after rr_ptr.
    always_comb begin
        logic [1:0] cand;
        grant_vld_s = 1'b0;
        grant_s     = 2'd0;
        cand        = 2'd0;
        if (state_q == LOCKED) begin
            grant_vld_s = 1'b1;
            grant_s     = lock_ch_q;
        end else if (bus.sel_mode) begin
            grant_vld_s = 1'b1;
            grant_s     = bus.sel;
        end else begin
            // Scan from the farthest offset down so the nearest valid channel wins.
            for (int i = 4; i >= 1; i--) begin
                cand        = rr_ptr_q + 2'(i);
                grant_s     = bus.in_valid[cand] ? cand : grant_s;
                grant_vld_s = grant_vld_s | bus.in_valid[cand];
            end
        end
    end

    // Ready is offered to the candidate regardless of its own valid.
    always_comb begin
        in_ready_s = 4'b0000;
        if (grant_vld_s && load_s && !reset) begin
            in_ready_s = 4'b0001 << grant_s;
        end else begin
            in_ready_s = 4'b0000;
        end
    end

    // Data path select for the granted channel.
    always_comb begin
        grant_data_s = {W{1'b0}};
        case (grant_s)
            2'd0:    grant_data_s = bus.d_in_1;
            2'd1:    grant_data_s = bus.d_in_2;
            2'd2:    grant_data_s = bus.d_in_3;
            2'd3:    grant_data_s = bus.d_in_4;
            default: grant_data_s = {W{1'b0}};
        endcase
    end

    // Next-state for output register, burst lock and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        d_out_d     = d_out_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (xfer_s) begin
            d_out_d     = grant_data_s;
            out_src_d   = grant_s;
            out_valid_d = 1'b1;
            out_last_d  = burst_end_s;
            if (burst_end_s) begin
                state_d    = IDLE;
                beat_cnt_d = {CW{1'b0}};
                rr_ptr_d   = grant_s;
            end else begin
                state_d    = LOCKED;
                lock_ch_d  = grant_s;
                beat_cnt_d = beat_cnt_q + CW'(1);
            end
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset; rr_ptr=3 gives channel 0 first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_ch_q   <= 2'd0;
            rr_ptr_q    <= 2'd3;
            beat_cnt_q  <= {CW{1'b0}};
            d_out_q     <= {W{1'b0}};
            out_src_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            d_out_q     <= d_out_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.d_out     = d_out_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_mux_array_gather.sv
// Bench for mux_array_gather: directed scenarios plus random traffic, checked
// against a beat-counting reference model (BURST_LEN=4) and a BURST_LEN=1 instance.
module tb_mux_array_gather;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    mux_array_gather_if #(.array_size(9), .data_size(8)) ifc ();
    mux_array_gather_if #(.array_size(9), .data_size(8)) ifc1 ();

    mux_array_gather #(.array_size(9), .data_size(8), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .bus(ifc));
    mux_array_gather #(.array_size(9), .data_size(8), .BURST_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1));

    always #5 clk = ~clk;

    // Reference model state: who owns the output, beats done in this burst, last served channel.
    int          m_owner;
    int          m_beats;
    int          m_last;
    bit          m_valid;
    logic [71:0] m_data;
    logic [1:0]  m_src;
    bit          m_lflag;
    logic [7:0]  base [4];
    int          cnt  [4];
    logic [71:0] din_w [4];
    logic [71:0] w1 [4];

    task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic apply_din();
        for (int k = 0; k < 4; k++) din_w[k] = {9{8'(base[k] + 8'(cnt[k]))}};
        ifc.d_in_1 = din_w[0];
        ifc.d_in_2 = din_w[1];
        ifc.d_in_3 = din_w[2];
        ifc.d_in_4 = din_w[3];
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = 3;
        m_valid = 1'b0; m_data = 72'h0; m_src = 2'd0; m_lflag = 1'b0;
    endtask

    // One clock: predict and check in_ready, step the model, then check the registered outputs.
    task automatic cycle();
        int g; bit gv; bit ld; bit xf; logic [3:0] er;
        #1;
        ld = !m_valid || ifc.out_ready;
        gv = 1'b0; g = 0;
        if (m_owner >= 0) begin
            gv = 1'b1; g = m_owner;
        end else if (ifc.sel_mode) begin
            gv = 1'b1; g = int'(ifc.sel);
        end else begin
            for (int s = 1; s <= 4; s++)
                if (!gv && ifc.in_valid[(m_last + s) % 4]) begin gv = 1'b1; g = (m_last + s) % 4; end
        end
        er = (gv && ld && !reset) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 72'(ifc.in_ready), 72'(er));
        xf = gv && ld && !reset && ifc.in_valid[g];
        if (reset) begin
            model_reset();
        end else if (xf) begin
            m_data = din_w[g]; m_src = 2'(g); m_valid = 1'b1;
            m_lflag = (m_beats == BL - 1);
            m_beats++;
            if (m_beats == BL) begin m_beats = 0; m_owner = -1; m_last = g; end
            else m_owner = g;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
        if (xf) begin cnt[g]++; apply_din(); end
        check("out_valid", 72'(ifc.out_valid), 72'(m_valid));
        if (m_valid) begin
            check("d_out", ifc.d_out, m_data);
            check("out_src", 72'(ifc.out_src), 72'(m_src));
            check("out_last", 72'(ifc.out_last), 72'(m_lflag));
        end
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [71:0] hold_d;
        logic [1:0]  hold_s;
        int nb1; bit seen2;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            base[k] = 8'h10 * 8'(k + 1); cnt[k] = 0;
            w1[k] = {9{8'(8'hA0 + 8'(k))}};
        end
        apply_din();
        ifc.in_valid = 4'b1111; ifc.out_ready = 1'b1; ifc.sel_mode = 1'b0; ifc.sel = 2'd0;
        ifc1.d_in_1 = w1[0]; ifc1.d_in_2 = w1[1]; ifc1.d_in_3 = w1[2]; ifc1.d_in_4 = w1[3];
        ifc1.in_valid = 4'b1111; ifc1.out_ready = 1'b1; ifc1.sel_mode = 1'b0; ifc1.sel = 2'd0;

        // 1: reset held 3 cycles with all channels valid
        do_reset(3);
        check("rst_d_out", ifc.d_out, 72'h0);
        check("rst_d_out_b1", ifc1.d_out, 72'h0);
        check("rst_ready_b1", 72'(ifc1.in_ready), 72'h0);

        // 2: BURST_LEN=1 round-robin 0,1,2,3,0 (BURST_LEN=4 instance runs under the model)
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 0) check("first_grant", 72'(ifc.out_src), 72'h0);
            check("rr_valid", 72'(ifc1.out_valid), 72'h1);
            check("rr_src", 72'(ifc1.out_src), 72'(i % 4));
            check("rr_last", 72'(ifc1.out_last), 72'h1);
            check("rr_data", ifc1.d_out, w1[i % 4]);
        end

        // 3: burst lock on ch1 with a two-cycle valid drop mid-burst
        do_reset(1);
        base[1] = 8'h11; cnt[1] = 0; base[2] = 8'h21; cnt[2] = 0; apply_din();
        ifc.in_valid = 4'b0110;
        nb1 = 0; seen2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (ifc.out_valid && ifc.out_src == 2'd1) nb1++;
            if (ifc.out_valid && ifc.out_src == 2'd1 && ifc.out_last)
                check("burst_last_data", ifc.d_out, {9{8'h14}});
            if (ifc.out_valid && ifc.out_src == 2'd2 && !seen2) begin
                seen2 = 1'b1;
                check("ch2_after_burst", 72'(nb1), 72'd4);
            end
            if (i == 1) ifc.in_valid = 4'b0100;
            if (i == 3) ifc.in_valid = 4'b0110;
        end
        check("ch1_beats", 72'(nb1), 72'd4);
        check("ch2_seen", 72'(seen2), 72'h1);

        // 4: downstream backpressure for 5 cycles
        do_reset(1);
        ifc.in_valid = 4'b1111;
        repeat (2) cycle();
        hold_d = ifc.d_out; hold_s = ifc.out_src;
        ifc.out_ready = 1'b0;
        repeat (5) cycle();
        check("stall_d_out", ifc.d_out, hold_d);
        check("stall_src", 72'(ifc.out_src), 72'(hold_s));
        ifc.out_ready = 1'b1;
        repeat (6) cycle();

        // 5: fixed select, sel changed at beat 2
        do_reset(1);
        ifc.sel_mode = 1'b1; ifc.sel = 2'd3;
        repeat (2) cycle();
        ifc.sel = 2'd0;
        cycle();
        check("fix_b3_src", 72'(ifc.out_src), 72'd3);
        cycle();
        check("fix_b4_src", 72'(ifc.out_src), 72'd3);
        check("fix_b4_last", 72'(ifc.out_last), 72'h1);
        cycle();
        check("fix_next_src", 72'(ifc.out_src), 72'd0);

        // 6: reset after beat 2 abandons the burst
        do_reset(1);
        ifc.sel_mode = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        check("midrst_valid", 72'(ifc.out_valid), 72'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("restart_src", 72'(ifc.out_src), 72'h0);
            check("restart_last", 72'(ifc.out_last), 72'(i == 3));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ifc.in_valid  = 4'($urandom);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) ifc.sel_mode = 1'($urandom);
            if ($urandom_range(0, 7) == 0) ifc.sel = 2'($urandom);
            if ($urandom_range(0, 31) == 0) base[$urandom_range(0, 3)] = 8'($urandom);
            apply_din();
            reset = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
